// File: rtl/moore_uart_tx_if.sv
// ---------------------------------------------------------------------------
// moore_uart_tx_if
//
// Groups the parallel request side and the serial/status side of the UART
// transmitter into one bundle.
//
//   tx_start : request to send tx_data (only honoured while the transmitter
//              is idle)
//   tx_data  : DATA_BITS-wide word, captured when the request is accepted
//   tx       : serial line, idle high
//   tx_busy  : high while a frame is on the line
//   tx_done  : one-cycle pulse right after the stop bit ends
//
// Modports:
//   master : the word producer (drives tx_start/tx_data, observes the rest)
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface moore_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/moore_uart_tx.sv
// ---------------------------------------------------------------------------
// moore_uart_tx
//
// Moore-style asynchronous serial transmitter. A parallel word is accepted
// while idle and shifted out as: start bit (0), DATA_BITS data bits LSB
// first, an optional even-parity bit, and one stop bit (1). Every bit is
// held for CLKS_PER_BIT clocks.
//
// All FSM outputs are decoded from the state alone and then registered, so
// tx/tx_busy/tx_done are glitch-free and lag the state register by exactly
// one clock. tx_start sampled at edge k therefore makes tx fall after k+1.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset; forces tx=1, tx_busy=0,
//            tx_done=0 immediately and aborts any frame in flight
//   bus    : moore_uart_tx_if.slave (tx_start, tx_data, tx, tx_busy, tx_done)
//
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit, >= 2
//   DATA_BITS    : data bits per frame, 5..9
//
// Build option:
//   MOORE_UART_TX_PARITY_EN : when defined, a PARITY state carrying the
//   even-parity bit of the captured word is inserted between the last data
//   bit and the stop bit. When undefined, no parity logic exists at all.
// ---------------------------------------------------------------------------
module moore_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic            clk,
    input  logic            reset,
    moore_uart_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // Elaboration-time guard on the legal parameter ranges.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("moore_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("moore_uart_tx: DATA_BITS must be in 5..9");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MOORE_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef MOORE_UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Decoded (pre-register) Moore outputs.
    logic                 tx_dec;
    logic                 busy_dec;
    logic                 done_dec;

    // Registered pin drivers.
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 bit_tick;
    logic [CNT_W-1:0]     cnt_step;

    assign bit_tick = (cnt_q == CNT_LAST);
    assign cnt_step = bit_tick ? '0 : cnt_q + 1'b1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
`ifdef MOORE_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
`ifdef MOORE_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef MOORE_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        tx_dec   = 1'b1;
        busy_dec = 1'b0;
        done_dec = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    shift_d  = bus.tx_data;
`ifdef MOORE_UART_TX_PARITY_EN
                    // Even parity is fixed at accept so later tx_data
                    // changes cannot disturb the frame.
                    parity_d = ^bus.tx_data;
`endif
                    cnt_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                tx_dec   = 1'b0;
                busy_dec = 1'b1;
                cnt_d    = cnt_step;
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                tx_dec   = shift_q[0];
                busy_dec = 1'b1;
                cnt_d    = cnt_step;
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef MOORE_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef MOORE_UART_TX_PARITY_EN
            PARITY: begin
                tx_dec   = parity_q;
                busy_dec = 1'b1;
                cnt_d    = cnt_step;
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                busy_dec = 1'b1;
                cnt_d    = cnt_step;
                if (bit_tick) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Single cycle; busy already low so a held tx_start is
                // accepted on the following IDLE cycle.
                done_dec = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output register stage: pins lag the state by one clock, glitch-free
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_dec;
            busy_q <= busy_dec;
            done_q <= done_dec;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: doc/moore_uart_tx.md
Name: moore_uart_tx

Overview:
- Moore-style serial transmitter: accepts a parallel word and shifts it out as an asynchronous UART frame (start bit, data bits LSB first, optional parity, stop bit).
- It is the transmit end of the serial link whose receiver is built from the team's Moore FSM template.
- FSM outputs are decoded from state only, then passed through an output D-FF stage so that `tx` is glitch-free.

Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be >= 2.
- `DATA_BITS`, 8: number of data bits per frame. Range 5..9.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `tx_start`  input  1  request to send `tx_data`; sampled only in IDLE.
- `tx_data`  input  DATA_BITS  word to transmit; captured on accept.
- `tx`  output  1  serial line, registered; idle high.
- `tx_busy`  output  1  registered; high while a frame is in progress.
- `tx_done`  output  1  registered; one-cycle pulse at end of frame.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `state_reg`=IDLE; baud counter, bit index and shift register cleared.
  - `tx`=1, `tx_busy`=0, `tx_done`=0 immediately, without waiting for a clock edge.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP, DONE.
- Baud counter `cnt` runs 0..CLKS_PER_BIT-1 in every non-IDLE/non-DONE state. A "bit tick" occurs when `cnt`=CLKS_PER_BIT-1; `cnt` wraps to 0 on the tick.
- IDLE: decoded tx=1, busy=0. If `tx_start`=1: capture `tx_data` into the shift register, clear `cnt`, go to START. Otherwise stay.
- START: decoded tx=0, busy=1. On tick: go to DATA, bit index=0.
- DATA: decoded tx=`shift[0]`, busy=1. On tick:
  - shift right, bit index+1;
  - after bit index DATA_BITS-1: go to PARITY if the feature is compiled in, else STOP.
- STOP: decoded tx=1, busy=1. On tick: go to DONE.
- DONE: one cycle. Decoded tx=1, busy=0, done=1. Unconditionally go to IDLE.
- Output stage: decoded tx/busy/done are registered. The pins therefore lag `state_reg` by exactly one clock.
- Latency: `tx_start` sampled at edge k → `tx` falls after edge k+1.
- Frame length on `tx`: (DATA_BITS+2[+1 with parity])·CLKS_PER_BIT cycles. `tx_done` is high for the one cycle immediately after the stop bit ends.
- Back-to-back: with `tx_start` held high, the next frame is accepted in the IDLE cycle after DONE. This gives exactly 2 idle-high cycles between stop bit and next start bit.
- `tx_start` in any state other than IDLE is ignored; there is no queueing.
- `tx_data` changes after accept do not affect the frame in flight.
- Reset mid-frame aborts the frame: line returns high at once, and no `tx_done` pulse is produced.
- Unreachable state encodings go to IDLE (default case).

Optional Feature:
- Macro: `MOORE_UART_TX_PARITY_EN`.
- Defined: PARITY state is inserted after DATA.
  - It drives the even-parity bit (XOR of the captured word, computed at accept) for CLKS_PER_BIT cycles, then goes to STOP.
  - Frame length = (DATA_BITS+3)·CLKS_PER_BIT.
- Undefined: PARITY state and parity logic are absent; DATA goes directly to STOP.

Test Plan:
1. Reset/idle: `reset`=0 mid-cycle → `tx`=1, `tx_busy`=0, `tx_done`=0 before the next edge. Release with `tx_start`=0 for 20 cycles → outputs unchanged.
2. Single frame, CLKS_PER_BIT=4, DATA_BITS=8, `tx_data`=0xA5, no parity:
   - `tx`=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each held 4 cycles, then 1 for 4 cycles;
   - 40 cycles total; `tx_busy` high for exactly those 40 cycles;
   - `tx_done` high for 1 cycle right after them.
3. Parity build, `tx_data`=0x07, CLKS_PER_BIT=4 → data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop; frame 44 cycles. With `tx_data`=0xA5, parity bit = 0.
4. Ignore while busy: start 0x3C, pulse `tx_start` with `tx_data`=0xFF at cycle 10 of the frame → frame bits remain 0x3C; no second frame follows.
5. Back-to-back: hold `tx_start`=1 with 0x55 then 0xAA → two complete frames separated by exactly 2 high cycles; `tx_done` pulses twice.
6. Reset mid-frame: assert `reset`=0 during data bit 3 → `tx`=1 and `tx_busy`=0 immediately; no `tx_done`. After release, a new 0x81 frame transmits correctly.
